// File: rtl/uart_packet_rx.sv
// UART byte-stream packet receiver: hunts for a sync byte, assembles PKT_BYTES bytes MSB-first, hands off via valid/ready.
// Optional trailing XOR checksum byte when UART_PACKET_RX_CHECKSUM_EN is defined.
module uart_packet_rx #(
  parameter int          PKT_BYTES = 22,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5,
  parameter int          TIMEOUT   = 50000,
  parameter int          TO_W      = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rx_valid,
  input  logic [7:0]             rx_data,
  output logic [8*PKT_BYTES-1:0] pkt_data,
  output logic                   pkt_valid,
  input  logic                   pkt_ready,
  output logic                   busy,
  output logic                   overrun,
  output logic                   timeout_err,
  output logic                   chk_err
);

  localparam int W  = 8*PKT_BYTES;
  localparam int CW = $clog2(PKT_BYTES+1);

`ifdef UART_PACKET_RX_CHECKSUM_EN
  localparam int SW = W;
  typedef enum logic [1:0] {HUNT, COLLECT, CHECK} state_t;
  logic [7:0] xor_acc;
`else
  // Without CHECK the final byte is committed straight from rx_data, so the top byte is never stored.
  localparam int SW = W - 8;
  typedef enum logic [1:0] {HUNT, COLLECT} state_t;
`endif

  state_t          state;
  logic [SW-1:0]   shift;
  logic [CW-1:0]   byte_cnt;
  logic [TO_W-1:0] to_cnt;
  logic [W-1:0]    next_shift;
  logic [W-1:0]    commit_data;
  logic            last_byte;
  logic            to_expire;
  logic            do_commit;

  assign next_shift = {shift[W-9:0], rx_data};
  assign last_byte  = (byte_cnt == CW'(PKT_BYTES-1));
  assign to_expire  = (to_cnt == TO_W'(TIMEOUT-1));
  assign busy       = (state != HUNT);

`ifdef UART_PACKET_RX_CHECKSUM_EN
  assign do_commit   = (state == CHECK) && rx_valid && (rx_data == xor_acc);
  assign commit_data = shift;
`else
  assign do_commit   = (state == COLLECT) && rx_valid && last_byte;
  assign commit_data = next_shift;
  assign chk_err     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= HUNT;
      shift       <= '0;
      byte_cnt    <= '0;
      to_cnt      <= '0;
      pkt_data    <= '0;
      pkt_valid   <= 1'b0;
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
`ifdef UART_PACKET_RX_CHECKSUM_EN
      chk_err     <= 1'b0;
      xor_acc     <= '0;
`endif
    end else begin
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
`ifdef UART_PACKET_RX_CHECKSUM_EN
      chk_err     <= 1'b0;
`endif
      // A commit coinciding with a consumer accept replaces the held packet.
      if (do_commit) begin
        if (!pkt_valid || pkt_ready) begin
          pkt_data  <= commit_data;
          pkt_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (pkt_valid && pkt_ready) begin
        pkt_valid <= 1'b0;
      end

      case (state)
        HUNT: begin
          if (rx_valid && rx_data == SYNC_BYTE) begin
            state    <= COLLECT;
            byte_cnt <= '0;
            to_cnt   <= '0;
`ifdef UART_PACKET_RX_CHECKSUM_EN
            xor_acc  <= '0;
`endif
          end
        end
        COLLECT: begin
          if (rx_valid) begin
            shift    <= next_shift[SW-1:0];
            byte_cnt <= byte_cnt + 1'b1;
            to_cnt   <= '0;
`ifdef UART_PACKET_RX_CHECKSUM_EN
            xor_acc  <= xor_acc ^ rx_data;
            if (last_byte) state <= CHECK;
`else
            if (last_byte) state <= HUNT;
`endif
          end else if (to_expire) begin
            state       <= HUNT;
            timeout_err <= 1'b1;
            shift       <= '0;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
`ifdef UART_PACKET_RX_CHECKSUM_EN
        CHECK: begin
          if (rx_valid) begin
            state <= HUNT;
            if (rx_data != xor_acc) chk_err <= 1'b1;
          end else if (to_expire) begin
            state       <= HUNT;
            timeout_err <= 1'b1;
            shift       <= '0;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
`endif
        default: state <= HUNT;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_packet_rx.sv
// Bench for uart_packet_rx: queue-based packet model checked every cycle, plus directed literal checks.
module tb_uart_packet_rx;
  localparam int PKT = 22;
  localparam int W   = 8*PKT;
  localparam int TMO = 200;

  logic         clk = 1'b0;
  logic         rst, rx_valid, pkt_ready;
  logic [7:0]   rx_data;
  logic [W-1:0] pkt_data;
  logic         pkt_valid, busy, overrun, timeout_err, chk_err;

  always #5 clk = ~clk;

  uart_packet_rx #(.PKT_BYTES(PKT), .SYNC_BYTE(8'hA5), .TIMEOUT(TMO), .TO_W(16)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
    .pkt_data(pkt_data), .pkt_valid(pkt_valid), .pkt_ready(pkt_ready),
    .busy(busy), .overrun(overrun), .timeout_err(timeout_err), .chk_err(chk_err)
  );

  int vectors = 0;
  int errors  = 0;
  bit checking = 1'b0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Model: bytes since sync in a queue, idle cycles since last byte, held packet.
  bit           m_hunt = 1'b1;
  logic [7:0]   m_q[$];
  int           m_idle;
  logic [W-1:0] m_data;
  bit           m_valid, m_ovr, m_to, m_chk, m_commit, m_consumed;
  logic [7:0]   m_x;

  always @(posedge clk) begin
    m_ovr = 0; m_to = 0; m_chk = 0; m_commit = 0;
    if (rst) begin
      m_hunt = 1; m_q.delete(); m_idle = 0; m_data = '0; m_valid = 0;
    end else begin
      m_consumed = m_valid && pkt_ready;
      if (m_hunt) begin
        if (rx_valid && rx_data == 8'hA5) begin
          m_hunt = 0; m_q.delete(); m_idle = 0;
        end
      end else if (rx_valid) begin
        m_idle = 0;
        if (m_q.size() < PKT) begin
          m_q.push_back(rx_data);
`ifndef UART_PACKET_RX_CHECKSUM_EN
          if (m_q.size() == PKT) begin m_commit = 1; m_hunt = 1; end
`endif
        end else begin
          m_x = '0;
          foreach (m_q[i]) m_x ^= m_q[i];
          m_hunt = 1;
          if (rx_data == m_x) m_commit = 1; else m_chk = 1;
        end
      end else begin
        m_idle++;
        if (m_idle == TMO) begin m_to = 1; m_hunt = 1; end
      end
      if (m_commit) begin
        if (!m_valid || m_consumed) begin
          for (int i = 0; i < PKT; i++) m_data[W-1-8*i -: 8] = m_q[i];
          m_valid = 1;
        end else m_ovr = 1;
      end else if (m_consumed) m_valid = 0;
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      check("pkt_valid",   W'(pkt_valid),   W'(m_valid));
      check("pkt_data",    pkt_data,        m_data);
      check("busy",        W'(busy),        W'(!m_hunt));
      check("overrun",     W'(overrun),     W'(m_ovr));
      check("timeout_err", W'(timeout_err), W'(m_to));
      check("chk_err",     W'(chk_err),     W'(m_chk));
    end
  end

  logic [7:0] pkt_buf [PKT];

  task automatic fill(input logic [7:0] base);
    for (int i = 0; i < PKT; i++) pkt_buf[i] = base + 8'(i);
  endtask

  task automatic send(input logic [7:0] b, input int idle);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (idle) @(negedge clk);
  endtask

  // Returns at the negedge right after the final byte was captured.
  task automatic send_pkt(input int sp, input int long_at, input bit rdy_last);
`ifdef UART_PACKET_RX_CHECKSUM_EN
    logic [7:0] x;
    x = '0;
    for (int i = 0; i < PKT; i++) x ^= pkt_buf[i];
`endif
    send(8'hA5, sp);
    for (int i = 0; i < PKT-1; i++) send(pkt_buf[i], (i == long_at) ? TMO-1 : sp);
`ifdef UART_PACKET_RX_CHECKSUM_EN
    send(pkt_buf[PKT-1], sp);
    if (rdy_last) pkt_ready = 1'b1;
    send(x, 0);
`else
    if (rdy_last) pkt_ready = 1'b1;
    send(pkt_buf[PKT-1], 0);
`endif
  endtask

  initial begin
    rst = 1'b1; rx_valid = 1'b0; rx_data = '0; pkt_ready = 1'b1;
    repeat (3) @(negedge clk);
    checking = 1'b1;
    check("reset_valid", W'(pkt_valid), '0);
    check("reset_data",  pkt_data,      '0);
    check("reset_busy",  W'(busy),      '0);
    rst = 1'b0;
    @(negedge clk);

    // Basic packet, slow byte rate
    fill(8'h00);
    send_pkt(100, -1, 1'b0);
    check("t1_valid", W'(pkt_valid), W'(1));
    check("t1_msb",   W'(pkt_data[175:168]), W'(8'h00));
    check("t1_lsb",   W'(pkt_data[7:0]),     W'(8'h15));
    check("t1_data",  pkt_data, 176'h000102030405060708090a0b0c0d0e0f101112131415);
    @(negedge clk);
    check("t1_pulse", W'(pkt_valid), '0);

    // Junk before sync, sync value inside payload
    send(8'h11, 3); send(8'h22, 3);
    for (int i = 0; i < PKT; i++) pkt_buf[i] = 8'hFF;
    pkt_buf[3] = 8'hA5;
    send_pkt(3, -1, 1'b0);
    check("t2_data", pkt_data, {{3{8'hFF}}, 8'hA5, {18{8'hFF}}});
    repeat (3) @(negedge clk);

    // Inter-byte timeout
    send(8'hA5, 2);
    for (int i = 0; i < 10; i++) send(8'h30 + 8'(i), (i == 9) ? 0 : 2);
    repeat (TMO-1) @(negedge clk);
    check("t3_pre_to",  W'(timeout_err), '0);
    check("t3_pre_busy", W'(busy), W'(1));
    @(negedge clk);
    check("t3_to",    W'(timeout_err), W'(1));
    check("t3_busy",  W'(busy), '0);
    check("t3_valid", W'(pkt_valid), '0);
    @(negedge clk);

    // Full packet with one gap exactly at the timeout boundary
    fill(8'h30);
    send_pkt(2, 5, 1'b0);
    check("t3b_valid", W'(pkt_valid), W'(1));
    check("t3b_byte5", W'(pkt_data[135:128]), W'(8'h35));
    repeat (3) @(negedge clk);

    // Overrun with output held
    pkt_ready = 1'b0;
    fill(8'h40); send_pkt(2, -1, 1'b0);
    check("t4_held", W'(pkt_valid), W'(1));
    fill(8'h80); send_pkt(2, -1, 1'b0);
    check("t4_ovr",  W'(overrun), W'(1));
    check("t4_msb",  W'(pkt_data[175:168]), W'(8'h40));
    check("t4_lsb",  W'(pkt_data[7:0]),     W'(8'h55));
    @(negedge clk);
    check("t4_ovr_pulse", W'(overrun), '0);
    pkt_ready = 1'b1;
    @(negedge clk);
    pkt_ready = 1'b0;
    check("t4_drained", W'(pkt_valid), '0);

    // Simultaneous accept and commit
    fill(8'h60); send_pkt(2, -1, 1'b0);
    fill(8'h20); send_pkt(2, -1, 1'b1);
    pkt_ready = 1'b0;
    check("t4b_ovr",   W'(overrun), '0);
    check("t4b_valid", W'(pkt_valid), W'(1));
    check("t4b_msb",   W'(pkt_data[175:168]), W'(8'h20));
    check("t4b_lsb",   W'(pkt_data[7:0]),     W'(8'h35));
    repeat (2) @(negedge clk);

    // Reset mid-packet with a packet held
    send(8'hA5, 2);
    for (int i = 1; i <= 5; i++) send(8'(i), 2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t5_valid", W'(pkt_valid), '0);
    check("t5_data",  pkt_data, '0);
    check("t5_busy",  W'(busy), '0);
    pkt_ready = 1'b1;
    for (int i = 6; i <= 22; i++) send(8'(i), 2);
`ifdef UART_PACKET_RX_CHECKSUM_EN
    send(8'h17, 2);
`endif
    check("t5_nopkt", W'(pkt_valid), '0);
    check("t5_idle",  W'(busy), '0);

`ifdef UART_PACKET_RX_CHECKSUM_EN
    // Checksum good then bad
    fill(8'h01);
    send_pkt(2, -1, 1'b0);
    check("t6_valid", W'(pkt_valid), W'(1));
    check("t6_chk0",  W'(chk_err), '0);
    repeat (3) @(negedge clk);
    send(8'hA5, 2);
    for (int i = 0; i < PKT; i++) send(pkt_buf[i], 2);
    send(8'h00, 0);
    check("t6_chk",   W'(chk_err), W'(1));
    check("t6_drop",  W'(pkt_valid), '0);
`endif

    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/uart_packet_rx.md
Name: uart_packet_rx

Overview:
- Receive-side counterpart of the packet-to-UART printer.
- Consumes bytes from the UART receiver (received / rx_byte strobes) and hunts for a sync byte.
- Assembles the following PKT_BYTES bytes into a 176-bit packet, most-significant byte first, matching the transmit byte order.
- Presents the packet on a valid/ready interface with an inter-byte timeout and overrun detection.

Parameters:
- PKT_BYTES, 22, payload bytes per packet; packet width is 8*PKT_BYTES = 176.
- SYNC_BYTE, 8'hA5, header byte that starts a packet.
- TIMEOUT, 50000, max clk cycles allowed between consecutive payload bytes.
- TO_W, 16, timeout counter width; must satisfy TIMEOUT < 2**TO_W.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset.
- rx_valid  in  1  one-cycle strobe: rx_data holds a received byte.
- rx_data  in  8  received byte.
- pkt_data  out  8*PKT_BYTES  assembled packet; first payload byte in [175:168].
- pkt_valid  out  1  pkt_data holds an unconsumed packet.
- pkt_ready  in  1  consumer accepts pkt_data when pkt_valid & pkt_ready.
- busy  out  1  high while in COLLECT or CHECK.
- overrun  out  1  one-cycle pulse: completed packet dropped because the output was full.
- timeout_err  out  1  one-cycle pulse: packet aborted on inter-byte timeout.
- chk_err  out  1  one-cycle pulse: checksum mismatch; tied 0 when the feature is compiled out.

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk.
  - All state clears: state=HUNT; byte count, timeout count, shift register = 0.
  - Outputs: pkt_data=0, pkt_valid=0, busy=0, overrun=0, timeout_err=0, chk_err=0.
  - Reset mid-packet discards the partial packet and any held pkt_data.
- Two registers:
  - Internal shift register for the packet being collected.
  - Output holding register (pkt_data).
  - The next packet can be collected while the previous one is held.
- State HUNT:
  - rx_valid with rx_data==SYNC_BYTE -> COLLECT; byte count=0, timeout count=0.
  - Any other byte is ignored.
- State COLLECT:
  - Each rx_valid shifts rx_data in from the bottom (shift <= {shift[8*PKT_BYTES-9:0], rx_data}), increments the byte count and clears the timeout count.
  - A SYNC_BYTE value inside the payload is treated as data.
  - If rx_valid is absent, the timeout count increments.
  - Timeout count reaching TIMEOUT -> HUNT; timeout_err pulses one cycle and the partial data is discarded.
  - If rx_valid arrives in the same cycle the count would reach TIMEOUT, the byte wins: it is accepted and no timeout occurs.
  - On the cycle the PKT_BYTES-th byte is accepted -> commit; feature builds go to CHECK instead.
- Commit, one cycle after the last byte's rx_valid:
  - If pkt_valid==0, or pkt_valid & pkt_ready in the same cycle: load pkt_data and set pkt_valid=1. In the simultaneous-accept case the old packet is consumed and pkt_valid stays 1.
  - Otherwise the new packet is dropped and overrun pulses; pkt_data is unchanged.
  - Next state after a commit is HUNT.
- Output handshake:
  - pkt_valid & pkt_ready with no commit in that cycle -> pkt_valid=0 next cycle.
  - pkt_data is stable while pkt_valid=1 and changes only on a commit.
- busy = (state==COLLECT) | (state==CHECK).
- Latency: sync byte + PKT_BYTES bytes; pkt_valid rises the cycle after the final byte's rx_valid (feature build: after the checksum byte).

Optional Feature:
- Macro: UART_PACKET_RX_CHECKSUM_EN.
- Defined:
  - After PKT_BYTES payload bytes, state CHECK waits for one extra byte under the same timeout rule.
  - The expected value is the XOR of all payload bytes, accumulated as they arrive.
  - Match -> commit as above.
  - Mismatch -> drop the packet, pulse chk_err, return to HUNT.
- Undefined:
  - No CHECK state and no XOR accumulator.
  - Commit occurs directly after the last payload byte; chk_err is constant 0.

Test Plan:
- Reset then A5, 00..15 (22 bytes, 1 byte / 100 cycles), pkt_ready=1 -> pkt_valid pulses 1 cycle after the last byte; pkt_data[175:168]=00, [7:0]=15.
- Bytes 11, 22, then A5 + 22 bytes FF with an A5 at payload index 3 -> leading 11, 22 ignored; A5 at index 3 kept as data; pkt_data = FF..FF with A5 at [151:144].
- A5 + 10 bytes, then silence TIMEOUT cycles -> timeout_err pulses once, busy=0, pkt_valid stays 0; a following full packet is received correctly.
- Two back-to-back packets with pkt_ready=0 -> first held in pkt_data, second dropped with one overrun pulse; repeat with pkt_ready=1 on the second commit cycle -> no overrun, pkt_data becomes the second packet, pkt_valid stays 1.
- rst asserted after A5 + 5 bytes -> all outputs 0 next cycle; the remaining bytes without a fresh A5 produce no packet.
- UART_PACKET_RX_CHECKSUM_EN: payload 01..16 with checksum 17 (correct XOR) -> packet delivered; same payload with checksum 00 -> chk_err pulse, pkt_valid stays 0.
